rr_decoder_arbiter: RTL
=======================

// Module: rr_decoder_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 3x8-decoded resource (select line / bank) between 8 requesters.
//  Picks one requester and drives its 3-bit index plus the one-hot decoded select (same code as the Decoder3x8).
//  Holds the grant until release, request drop or timeout, then rotates priority.
//  Sits between the requesting units and the shared decoder-driven resource.
// PARAMETERS
//  MAX_HOLD  16  max cycles a grant may be held before forced revoke; legal range 1..255
// PORTS
//  clk           input   1  system clock, rising edge
//  rst_n         input   1  asynchronous active-low reset
//  req           input   8  request vector, bit i = requester i
//  release       input   1  current owner done; sampled only in GRANT
//  grant_addr    output  3  index of granted requester (decoder address)
//  grant_onehot  output  8  decoded select = 8'b1 << grant_addr while busy, else 8'h00
//  busy          output  1  a grant is active
//  timeout       output  1  one-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Clock/reset: one clock. Asynchronous active-low reset. All outputs registered.
//  Reset values: grant_addr=0, grant_onehot=0, busy=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
//  Reset asserted mid-grant: outputs clear immediately (async); after release of reset, arbitration restarts from ptr=0.
//  State machine: IDLE, GRANT, GAP.
//   IDLE:
//    - If req != 0 at edge k: winner = first set bit scanning ptr, ptr+1, ... mod 8.
//    - grant_addr=winner, busy=1, grant_onehot valid after edge k (latency 1 from req), hold_cnt=1 -> GRANT.
//    - If req == 0: stay in IDLE, outputs 0.
//   GRANT (checked each edge, priority order):
//    1. release=1 or req[grant_addr]=0 -> GAP, timeout=0.
//    2. else hold_cnt==MAX_HOLD -> GAP, timeout=1 for exactly one cycle.
//    3. else hold_cnt++ and hold the grant.
//   Simultaneous release and timeout: rule 1 wins, so no timeout pulse.
//   Leaving GRANT: ptr = grant_addr+1 mod 8 (7 wraps to 0), busy=0, grant_onehot=0.
//   Other requests arriving during GRANT never preempt the current owner.
//   GAP: exactly one idle cycle with all selects 0 (break-before-make on the decoder lines) -> IDLE.
//  Grant timing: grant_addr holds its last value while idle; consumers qualify it with busy.
//  Fairness: a continuously requesting agent waits at most 7 grants.
//  Widths: hold_cnt = $clog2(MAX_HOLD+1) bits and never wraps.
//  Invariants:
//   - grant_onehot has at most one bit set.
//   - grant_onehot != 0 iff busy.
// TESTING
//  Pass criteria: bench compares per-cycle against a golden file. On the first mismatch it prints the pattern number and stops.
//  1. Reset with req=8'hFF, then release reset -> grant_addr=0, grant_onehot=8'h01, busy=1 one edge later.
//  2. req=8'hFF, pulse release after each grant ->
//     - grant order 0,1,...,7,0
//     - busy low for exactly 1 cycle (GAP) plus 1 arbitration edge between grants.
//  3. req=8'h04 held and never released, MAX_HOLD=16 ->
//     - grant_onehot=8'h04 for 16 cycles, then timeout=1 for one cycle.
//     - Regrant of 2 after GAP.
//  4. Owner 3 granted; req[3] drops while req=8'h81 ->
//     - revoke, then next grant = 7 (ptr=4 scan), then 0.
//  5. release and hold_cnt==MAX_HOLD on the same edge -> timeout stays 0, ptr advances.
//  6. rst_n pulled low mid-GRANT (owner 5) -> outputs 0 without a clock edge; first grant after reset scans from 0.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one 3x8-decoded resource.
// It grants one owner until release, request drop or MAX_HOLD timeout, then leaves one idle gap cycle.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       release_i,
  output logic [2:0] grant_addr_o,
  output logic [7:0] grant_onehot_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]    addr_q, addr_d;
  logic [7:0]    onehot_q, onehot_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic [2:0]    win;
  logic          found;
  logic [2:0]    idx;

  // Rotating scan: the first set request at or after ptr_q wins.
  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    onehot_d   = onehot_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_GRANT;
          addr_d     = win;
          onehot_d   = 8'b1 << win;
          busy_d     = 1'b1;
          hold_cnt_d = CW'(1);
        end
      end
      S_GRANT: begin
        // Release or request drop outranks the hold limit, so no pulse then.
        if (release_i || !req_i[addr_q] || (hold_cnt_q == CW'(MAX_HOLD))) begin
          state_d    = S_GAP;
          ptr_d      = addr_q + 3'd1;
          onehot_d   = 8'h00;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          timeout_d  = !(release_i || !req_i[addr_q]);
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        onehot_d = 8'h00;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= '0;
      addr_q     <= 3'd0;
      onehot_q   <= 8'h00;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      onehot_q   <= onehot_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_addr_o   = addr_q;
  assign grant_onehot_o = onehot_q;
  assign busy_o         = busy_q;
  assign timeout_o      = timeout_q;
  assign state_o        = state_q;

endmodule
